// File: rtl/alu_operand_stage.sv
// Operand-select stage between decode and the ALU: forwards register data, picks ALU
// operands by opcode and registers them behind a 2-entry skid buffer (valid/ready on both sides).
module alu_operand_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         pc,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic [11:0]             imm12,
  input  logic [19:0]             u_imm20,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [NUM_FWD-1:0]      fwd_en,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         data0,
  output logic [XLEN-1:0]         data1,
  output logic                    alu_en,
  output logic [2:0]              funct3_out
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [XLEN-1:0] SHAMT_MASK = XLEN'(XLEN - 1);
  localparam logic [XLEN-1:0] LINK_OFS   = XLEN'(4);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_next;
  logic accept, drain, load_out, load_skid, skid_to_out;
  logic is_shift;

  logic signed [XLEN-1:0] imm_ext, u_ext;
  logic [XLEN-1:0] r1, r2;
  logic [XLEN-1:0] sel_data0_p0, sel_data1_p0;
  logic            sel_en_p0;
  logic [XLEN-1:0] skid_data0_p1, skid_data1_p1;
  logic            skid_en_p1;
  logic [2:0]      skid_funct3_p1;

  function automatic logic signed [XLEN-1:0] sext_imm(input logic signed [11:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] sext_u(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  // Stage p0: forwarding and operand selection on the incoming beat
  always_comb begin
    r1 = rs1_data;
    r2 = rs2_data;
    // Walk from the highest port down so the lowest-indexed match is applied last and wins.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_en[i] && (fwd_rd[5*i +: 5] == rs1) && (rs1 != 5'd0)) r1 = fwd_data[XLEN*i +: XLEN];
      if (fwd_en[i] && (fwd_rd[5*i +: 5] == rs2) && (rs2 != 5'd0)) r2 = fwd_data[XLEN*i +: XLEN];
    end
    imm_ext      = sext_imm(imm12);
    u_ext        = sext_u({u_imm20, 12'b0});
    is_shift     = (funct3 == 3'b001) || (funct3 == 3'b101);
    sel_data0_p0 = '0;
    sel_data1_p0 = '0;
    sel_en_p0    = 1'b1;
    case (opcode)
      OPC_OP_IMM: begin
        sel_data0_p0 = r1;
        sel_data1_p0 = is_shift ? XLEN'(imm12) : imm_ext;
      end
      OPC_OP: begin
        sel_data0_p0 = r1;
        sel_data1_p0 = is_shift ? (r2 & SHAMT_MASK) : r2;
      end
      OPC_LOAD, OPC_STORE: begin
        sel_data0_p0 = r1;
        sel_data1_p0 = imm_ext;
      end
      OPC_LUI: sel_data1_p0 = u_ext;
      OPC_AUIPC: begin
        sel_data0_p0 = pc;
        sel_data1_p0 = u_ext;
      end
      OPC_JAL, OPC_JALR: begin
        sel_data0_p0 = pc;
        sel_data1_p0 = LINK_OFS;
      end
      default: sel_en_p0 = 1'b0;
    endcase
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_next  = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_next = ONE;
        load_out   = 1'b1;
      end
      ONE: begin
        if (accept && !drain) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (!accept && drain) begin
          state_next = EMPTY;
        end else if (accept && drain) begin
          load_out = 1'b1;
        end
      end
      TWO: if (drain) begin
        state_next  = ONE;
        skid_to_out = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next  = EMPTY;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Stage p1: output register and skid entry
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      data0          <= '0;
      data1          <= '0;
      alu_en         <= 1'b0;
      funct3_out     <= 3'b0;
      skid_data0_p1  <= '0;
      skid_data1_p1  <= '0;
      skid_en_p1     <= 1'b0;
      skid_funct3_p1 <= 3'b0;
    end else begin
      if (load_out) begin
        data0      <= sel_data0_p0;
        data1      <= sel_data1_p0;
        alu_en     <= sel_en_p0;
        funct3_out <= funct3;
      end else if (skid_to_out) begin
        data0      <= skid_data0_p1;
        data1      <= skid_data1_p1;
        alu_en     <= skid_en_p1;
        funct3_out <= skid_funct3_p1;
      end
      if (load_skid) begin
        skid_data0_p1  <= sel_data0_p0;
        skid_data1_p1  <= sel_data1_p0;
        skid_en_p1     <= sel_en_p0;
        skid_funct3_p1 <= funct3;
      end
    end
  end

endmodule
